// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, redirect codes and
// the per-stage shadow record used by the RAW scoreboard.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_TRAP   = 2'd2
  } redirect_e;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [4:0] rd;
  } stage_rec_t;

  // EX, LS, WB
  localparam int NUM_STAGES = 3;

  function automatic logic rec_hits(stage_rec_t r, logic [4:0] rs);
    return r.vld & r.wr & (r.rd == rs);
  endfunction

endpackage

// File: rtl/riscv_pipeline_ctrl_if.sv
// Handshake bundle between the datapath stages (master) and the pipeline
// sequencer (slave).
interface riscv_pipeline_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   if_valid_i;
  logic                   id_valid_i;
  logic [4:0]             id_rs1_i;
  logic [4:0]             id_rs2_i;
  logic                   id_use_rs1_i;
  logic                   id_use_rs2_i;
  logic [4:0]             id_rd_i;
  logic                   id_wr_i;
  logic                   id_fence_i;
  logic                   ex_busy_i;
  logic                   ls_busy_i;
  logic                   ex_branch_i;
  logic                   ls_trap_i;
  logic                   if_en_o;
  logic                   id_en_o;
  logic                   ex_en_o;
  logic                   ls_en_o;
  logic                   wb_en_o;
  logic                   if_flush_o;
  logic                   id_flush_o;
  logic                   ex_flush_o;
  logic [1:0]             redirect_o;
  logic                   stall_o;
  logic [1:0]             state_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output if_valid_i, id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_wr_i, id_fence_i, ex_busy_i, ls_busy_i, ex_branch_i, ls_trap_i,
    input  if_en_o, id_en_o, ex_en_o, ls_en_o, wb_en_o, if_flush_o, id_flush_o,
           ex_flush_o, redirect_o, stall_o, state_o, stall_cnt_o
  );

  modport slave (
    input  if_valid_i, id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_wr_i, id_fence_i, ex_busy_i, ls_busy_i, ex_branch_i, ls_trap_i,
    output if_en_o, id_en_o, ex_en_o, ls_en_o, wb_en_o, if_flush_o, id_flush_o,
           ex_flush_o, redirect_o, stall_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/riscv_ctrl_scoreboard.sv
// Shadow {vld,wr,rd} records for EX/LS/WB and the stall-only RAW compare
// against the instruction sitting in ID.
module riscv_ctrl_scoreboard
  import riscv_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ex_en_i,
  input  logic                  ls_en_i,
  input  stage_rec_t            id_rec_i,
  input  logic                  ex_kill_i,
  input  logic                  ls_kill_i,
  input  logic                  id_valid_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  output logic [NUM_STAGES-1:0] vld_o,
  output logic                  raw_o
);

  stage_rec_t [NUM_STAGES-1:0] rec_q, rec_d;
  logic       [NUM_STAGES-1:0] hit1, hit2;

  // A stage that advances while its upstream holds (or is killed) takes a bubble.
  always_comb begin
    rec_d = rec_q;
    if (ex_en_i) rec_d[0] = id_rec_i;
    if (ls_en_i) rec_d[1] = (ex_en_i & ~ex_kill_i) ? rec_q[0] : '0;
    rec_d[2] = (ls_en_i & ~ls_kill_i) ? rec_q[1] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rec_q <= '0;
    else         rec_q <= rec_d;
  end

  // WB is compared too: the register file does not bypass same-cycle writes.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_cmp
    assign hit1[s]  = rec_hits(rec_q[s], rs1_i);
    assign hit2[s]  = rec_hits(rec_q[s], rs2_i);
    assign vld_o[s] = rec_q[s].vld;
  end

  assign raw_o = id_valid_i & ((use_rs1_i & (rs1_i != 5'd0) & (|hit1)) |
                               (use_rs2_i & (rs2_i != 5'd0) & (|hit2)));

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// Central sequencer for the 5-stage in-order pipeline: enable chain, flushes,
// redirect select, fence-drain/trap FSM and a saturating stall counter.
module riscv_pipeline_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  riscv_pipeline_ctrl_if.slave bus
);

  ctrl_state_e                  state_q, state_d;
  logic [STALL_CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]        vld;
  logic                         raw;
  logic                         ls_en, ex_en, id_en, if_en;
  logic                         branch, trap, stall;
  stage_rec_t                   id_rec;
  redirect_e                    redirect;
  logic                         unused_if_valid;

  // IF advance is purely enable-driven; its valid bit carries no control weight.
  assign unused_if_valid = bus.if_valid_i;

  assign ls_en  = ~bus.ls_busy_i;
  assign ex_en  = ls_en & ~bus.ex_busy_i;
  assign id_en  = ex_en & ~raw & (state_q == RUN);
  assign if_en  = id_en | (state_q == TRAP);

  assign branch = bus.ex_branch_i & vld[0] & ex_en;
  assign trap   = bus.ls_trap_i & vld[1] & ls_en;
  assign stall  = bus.id_valid_i & ~id_en;

  assign id_rec = '{vld: bus.id_valid_i & id_en & ~(branch | trap),
                    wr:  bus.id_wr_i,
                    rd:  bus.id_rd_i};

  riscv_ctrl_scoreboard u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ex_en_i    (ex_en),
    .ls_en_i    (ls_en),
    .id_rec_i   (id_rec),
    .ex_kill_i  (trap),
    .ls_kill_i  (trap),
    .id_valid_i (bus.id_valid_i),
    .use_rs1_i  (bus.id_use_rs1_i),
    .use_rs2_i  (bus.id_use_rs2_i),
    .rs1_i      (bus.id_rs1_i),
    .rs2_i      (bus.id_rs2_i),
    .vld_o      (vld),
    .raw_o      (raw)
  );

  // Trap outranks branch, which in turn squashes a fence trying to enter EX.
  always_comb begin
    state_d  = state_q;
    redirect = RD_NONE;
    unique case (state_q)
      RUN:     if (bus.id_valid_i & bus.id_fence_i & id_en & ~branch) state_d = DRAIN;
      DRAIN:   if (vld == '0) state_d = RUN;
      TRAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
    if (trap) begin
      state_d  = TRAP;
      redirect = RD_TRAP;
    end else if (branch) begin
      redirect = RD_BRANCH;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.if_en_o     = if_en;
  assign bus.id_en_o     = id_en;
  assign bus.ex_en_o     = ex_en;
  assign bus.ls_en_o     = ls_en;
  assign bus.wb_en_o     = 1'b1;
  assign bus.if_flush_o  = branch | trap;
  assign bus.id_flush_o  = branch | trap;
  assign bus.ex_flush_o  = trap;
  assign bus.redirect_o  = redirect;
  assign bus.stall_o     = stall;
  assign bus.state_o     = state_q;
  assign bus.stall_cnt_o = cnt_q;

endmodule
